// File: rtl/lcd_reader.sv
// Read-cycle sequencer for an HD44780-style character LCD: single reads of
// status or data RAM, or repeated status reads until the busy flag clears.
//
// state | meaning
// IDLE  | waiting for start; bus released (LCD_RW=0)
// SETUP | RS/RW stable ahead of the E rising edge
// EHIGH | E strobe high; panel drives LCD_data, sampled on the last cycle
// HOLD  | E low, RS/RW held for address hold time
// GAP   | E low recovery; decides between re-poll and completion
// DONE  | one-cycle completion pulse
module lcd_reader #(
   parameter int PW_E      = 24,
   parameter int T_AS      = 2,
   parameter int T_GAP     = 22,
   parameter int MAX_POLLS = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       RS,
   input  logic       poll,
   output logic [7:0] rdata,
   output logic       done,
   output logic       busy,
   output logic       timeout,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   input  logic [7:0] LCD_data
);

   localparam int TMAX = (PW_E > T_GAP) ? ((PW_E > T_AS) ? PW_E : T_AS)
                                        : ((T_GAP > T_AS) ? T_GAP : T_AS);
   localparam int TW   = $clog2(TMAX) + 1;
   localparam int PCW  = $clog2(MAX_POLLS + 1);

   typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, GAP, DONE} state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [PCW-1:0]   pcnt_q, pcnt_d;
   logic             poll_q, poll_d;
   logic             rs_q, rs_d;
   logic             to_q, to_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             e_q, rw_q, done_q, busy_q;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      pcnt_d  = pcnt_q;
      poll_d  = poll_q;
      rs_d    = rs_q;
      to_d    = to_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               rs_d    = RS & ~poll;
               poll_d  = poll;
               to_d    = 1'b0;
               pcnt_d  = '0;
               tmr_d   = TW'(T_AS - 1);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tmr_q == '0) begin
               tmr_d   = TW'(PW_E - 1);
               state_d = EHIGH;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         EHIGH: begin
            if (tmr_q == '0) begin
               rdata_d = LCD_data;
               state_d = HOLD;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         HOLD: begin
            tmr_d   = TW'(T_GAP - 1);
            state_d = GAP;
         end
         GAP: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TW'(1);
            end else if (poll_q && rdata_q[7]) begin
               // panel still busy: re-poll until the limit, then give up
               if (pcnt_q == PCW'(MAX_POLLS)) begin
                  to_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  pcnt_d  = pcnt_q + PCW'(1);
                  tmr_d   = TW'(T_AS - 1);
                  state_d = SETUP;
               end
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // strobe/status outputs are registered from the next state so they are glitch-free
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         pcnt_q  <= '0;
         poll_q  <= 1'b0;
         rs_q    <= 1'b0;
         to_q    <= 1'b0;
         rdata_q <= '0;
         e_q     <= 1'b0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pcnt_q  <= pcnt_d;
         poll_q  <= poll_d;
         rs_q    <= rs_d;
         to_q    <= to_d;
         rdata_q <= rdata_d;
         e_q     <= (state_d == EHIGH);
         rw_q    <= (state_d inside {SETUP, EHIGH, HOLD, GAP});
         done_q  <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign rdata   = rdata_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign timeout = to_q;
   assign LCD_RS  = rs_q;
   assign LCD_RW  = rw_q;
   assign LCD_E   = e_q;

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SHALL have parameter PW_E, default 24: E high width in clk cycles (480 ns at 50 MHz).
REQ-002 SHALL have parameter T_AS, default 2: RS/RW setup before E rises, in clk cycles.
REQ-003 SHALL have parameter T_GAP, default 22: E low recovery time after hold, in clk cycles.
REQ-004 SHALL have parameter MAX_POLLS, default 1000: busy-poll read limit before timeout.
REQ-005 SHALL have the port clk, input, 1 bit: 50 MHz clock; the block has one clock, and all logic runs on its rising edge.
REQ-006 SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have the port start, input, 1 bit: one-cycle read request from the host.
REQ-008 SHALL have the port RS, input, 1 bit: register select for a single read (0 = status/AC, 1 = data RAM).
REQ-009 SHALL have the port poll, input, 1 bit: when set, repeat status reads until the busy flag clears.
REQ-010 SHALL have the port rdata, output, 8 bits: last byte sampled from the LCD.
REQ-011 SHALL have the port done, output, 1 bit: one-cycle pulse when the transaction completes.
REQ-012 SHALL have the port busy, output, 1 bit: high while a transaction is in progress.
REQ-013 SHALL have the port timeout, output, 1 bit: set when a poll hits MAX_POLLS with the busy flag still 1.
REQ-014 SHALL have the port LCD_RS, output, 1 bit: LCD register select.
REQ-015 SHALL have the port LCD_RW, output, 1 bit: LCD read/write (1 = read).
REQ-016 SHALL have the port LCD_E, output, 1 bit: LCD enable strobe.
REQ-017 SHALL have the port LCD_data, input, 8 bits: LCD data bus as driven by the panel during a read.

Function
REQ-018 SHALL implement the states IDLE, SETUP, EHIGH, HOLD, GAP and DONE.
REQ-019 SHALL, in IDLE with start=1, latch RS into LCD_RS (forced to 0 when poll=1), latch poll, clear timeout and the poll counter, and enter SETUP.
REQ-020 SHALL ignore start whenever the state is not IDLE; there is no queueing.
REQ-021 SHALL drive LCD_RW=1 in SETUP, EHIGH, HOLD and GAP, and drive LCD_RW=0 in IDLE and DONE.
REQ-022 SHALL stay in SETUP for T_AS cycles, stay in EHIGH for PW_E cycles, stay in HOLD for 1 cycle and stay in GAP for T_GAP cycles.
REQ-023 SHALL assert LCD_E exactly while in EHIGH and in no other state.
REQ-024 SHALL register LCD_data into rdata on the clock edge that ends the last EHIGH cycle; rdata SHALL hold its value at all other times.
REQ-025 SHALL hold LCD_RS and LCD_RW constant from SETUP through HOLD, so address hold after E falls is at least 1 cycle.
REQ-026 SHALL, when poll=0, go from GAP to DONE.
REQ-027 SHALL, when poll=1 and the sampled bit 7 is 0, go from GAP to DONE.
REQ-028 SHALL, when poll=1, the sampled bit 7 is 1 and the poll count is below MAX_POLLS, increment the poll count and go from GAP to SETUP.
REQ-029 SHALL, when poll=1, the sampled bit 7 is 1 and the poll count equals MAX_POLLS, set timeout and go from GAP to DONE.
REQ-030 SHALL go from DONE to IDLE after exactly 1 cycle, and done SHALL equal (state==DONE).
REQ-031 SHALL drive busy as (state!=IDLE).
REQ-032 SHALL hold timeout until the next accepted start or reset.
REQ-033 SHALL make a single read take T_AS+PW_E+1+T_GAP+1 cycles (50 by default) from the start cycle to the done cycle, which meets the 1000 ns minimum E cycle time for back-to-back reads.
REQ-034 SHALL, with default parameters, make a poll sequence of n reads assert done 49n+1 cycles after start.
REQ-035 SHALL count polls in a counter wide enough for MAX_POLLS with no wrap-around.
REQ-036 SHALL accept a start that arrives in the cycle after done, since the state is IDLE by then.

Reset
REQ-037 SHALL, with reset low, force IDLE immediately without waiting for a clock edge: LCD_E=0, LCD_RW=0, LCD_RS=0, rdata=0, done=0, busy=0, timeout=0, poll count 0.
REQ-038 SHALL, when reset asserts during EHIGH, drop LCD_E at once, leave rdata at 0, and produce no done pulse.
REQ-039 SHALL, after reset is released, require a new start before any LCD_E pulse.

Verification
REQ-040 SHALL be verified by a single data read: start=1, RS=1, poll=0, LCD_data=8'h41 -> LCD_E high for 24 cycles, LCD_RW=1, rdata=8'h41, done in cycle 50.
REQ-041 SHALL be verified by a poll read: poll=1, LCD_data=8'h85 for 3 reads then 8'h05 -> four E pulses, LCD_RS=0, rdata=8'h05, done in cycle 197, timeout=0.
REQ-042 SHALL be verified by a poll timeout: MAX_POLLS=3, LCD_data held at 8'h80 -> four E pulses, timeout=1, done asserted, rdata=8'h80.
REQ-043 SHALL be verified by start during a transaction: a second start at cycle 10 -> ignored, only one E pulse, one done.
REQ-044 SHALL be verified by reset mid-operation: reset low at cycle 15 -> LCD_E and LCD_RW go to 0 within the same cycle, busy=0, no done pulse.
REQ-045 SHALL be verified by back-to-back reads: start in the cycle after done with RS=0 -> accepted, second done 50 cycles later, and LCD_E low for at least 26 cycles between the two pulses.
